// File: rtl/i2c_wb_bridge.sv
// Bridges an I2C-slave byte stream (control byte, address bytes, data bytes) onto
// single-beat Wishbone B3 classic master cycles, for both writes and prefetching reads.
module i2c_wb_bridge #(
    parameter int DW        = 32,
    parameter int AW        = 16,
    parameter int ADR_BYTES = 2,
    parameter int AUTO_INC  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      rx_dat_i,
    input  logic            rx_valid_i,
    input  logic            stop_i,
    output logic [7:0]      tx_dat_o,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            err_o,
    output logic            busy_o
);
    localparam int            SW        = DW / 8;
    localparam logic [1:0]    ADR_LAST  = 2'(ADR_BYTES - 1);
    localparam logic [1:0]    WORD_LAST = 2'(SW - 1);
    localparam logic [AW-1:0] ADR_STEP  = (AUTO_INC != 0) ? AW'(SW) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WB_WR,
        S_RD_REQ,
        S_TX
    } state_t;

    state_t        state_q, state_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          stop_q, stop_d;
    logic          err_q, err_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            adr_q   <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        stop_d  = stop_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (rx_valid_i && !stop_i) begin
                    rd_d    = rx_dat_i[0];
                    adr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i) begin
                    adr_d = AW'({adr_q, rx_dat_i});
                    if (cnt_q == ADR_LAST) begin
                        cnt_d = '0;
                        if (rd_q) begin
                            // Read cycle starts on the very first RD_REQ clock.
                            state_d = S_RD_REQ;
                            cyc_d   = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_WDATA: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (rx_valid_i) begin
                    dat_d = DW'({dat_q, rx_dat_i});
                    if (cnt_q == WORD_LAST) begin
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = S_WB_WR;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_WB_WR: begin
                // A stop here must not abort the bus cycle; remember it for later.
                stop_d = stop_q | stop_i;
                if (wb_ack_i || wb_err_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    if (wb_err_i) begin
                        err_d = 1'b1;
                    end else begin
                        adr_d = adr_q + ADR_STEP;
                    end
                    state_d = (stop_q || stop_i) ? S_IDLE : S_WDATA;
                end
            end
            S_RD_REQ: begin
                stop_d = stop_q | stop_i;
                if (wb_ack_i || wb_err_i) begin
                    cyc_d   = 1'b0;
                    dat_d   = wb_err_i ? '0 : wb_dat_i;
                    err_d   = err_q | wb_err_i;
                    cnt_d   = '0;
                    state_d = (stop_q || stop_i) ? S_IDLE : S_TX;
                end
            end
            S_TX: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (tx_ready_i) begin
                    dat_d = dat_q << 8;
                    if (cnt_q == WORD_LAST) begin
                        // Word fully sent: step the address and prefetch the next one.
                        cnt_d   = '0;
                        adr_d   = adr_q + ADR_STEP;
                        cyc_d   = 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_dat_o   = dat_q[DW-1 -: 8];
    assign tx_valid_o = (state_q == S_TX);
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = {SW{cyc_q}};
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;
    assign err_o      = err_q;
    assign busy_o     = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_wb_bridge.sv
// Bench for i2c_wb_bridge: table-driven write vectors, hand-written corner sequences,
// and randomized write/read traffic checked against a transaction-level memory model.
module tb_i2c_wb_bridge;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_dat;
    logic        rx_valid, stop, tx_ready;
    logic [7:0]  tx_dat;
    logic        tx_valid;
    logic [15:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack, wb_err, err, busy;

    always #5 clk_i = ~clk_i;

    i2c_wb_bridge #(.DW(32), .AW(16), .ADR_BYTES(2), .AUTO_INC(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_dat_i(rx_dat), .rx_valid_i(rx_valid), .stop_i(stop),
        .tx_dat_o(tx_dat), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
        .err_o(err), .busy_o(busy)
    );

    // Wishbone slave: every completed cycle is logged; memory content is the log itself.
    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic        err;
    } ev_t;
    ev_t evq[$];
    int  ack_delay = 0;
    int  err_req   = 0;
    int  err_done  = 0;
    int  wait_cnt  = 0;

    function automatic logic [31:0] mem_read(logic [15:0] a);
        for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].we && !evq[i].err && evq[i].adr == a) return evq[i].dat;
        return 32'h0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_i <= 32'h0;
            wait_cnt <= 0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt <= wait_cnt + 1;
                end else begin
                    wait_cnt <= 0;
                    if (err_done < err_req) begin
                        wb_err   <= 1'b1;
                        err_done <= err_done + 1;
                        evq.push_back('{we: wb_we, adr: wb_adr, dat: wb_dat_o, err: 1'b1});
                    end else begin
                        wb_ack <= 1'b1;
                        if (!wb_we) wb_dat_i <= mem_read(wb_adr);
                        evq.push_back('{we: wb_we, adr: wb_adr, dat: wb_dat_o, err: 1'b0});
                    end
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference memory: what a correct bridge must have written, by byte address.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_rd(logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    task automatic wait_no_cyc();
        int t = 0;
        while (wb_cyc && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (wb_cyc) check("cyc_timeout", {31'h0, wb_cyc}, 32'h0);
    endtask

    task automatic send_byte(logic [7:0] b);
        @(negedge clk_i);
        wait_no_cyc();
        rx_dat   = b;
        rx_valid = 1'b1;
        @(negedge clk_i);
        rx_valid = 1'b0;
    endtask

    task automatic send_stop();
        @(negedge clk_i);
        stop = 1'b1;
        @(negedge clk_i);
        stop = 1'b0;
    endtask

    task automatic send_hdr(logic rw, logic [15:0] a);
        send_byte({7'h0, rw});
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic send_word(logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    endtask

    task automatic wait_idle(string name);
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        check(name, {31'h0, busy}, 32'h0);
    endtask

    logic [7:0] rxb[$];
    task automatic collect(int n);
        int t = 0;
        bit r;
        rxb.delete();
        while (rxb.size() < n && t < 600) begin
            @(negedge clk_i);
            t++;
            r = ($urandom_range(0, 1) == 1);
            tx_ready = r;
            if (tx_valid && r) rxb.push_back(tx_dat);
        end
        @(negedge clk_i);
        tx_ready = 1'b0;
        check("tx_count", rxb.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [15:0] adr;
        int          nbytes;
        logic [31:0] d0;
        logic [31:0] d1;
        int          exp_n;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
    } wvec_t;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wvec_t       tbl[6];
        int          base, t, n;
        logic [7:0]  b;
        logic [15:0] a;
        logic [31:0] d, w;
        logic [15:0] waddrs[$];

        tbl[0] = '{16'h0010, 4, 32'hDEADBEEF, 32'h0,        1, 16'h0010, 16'h0000};
        tbl[1] = '{16'h0010, 8, 32'hDEADBEEF, 32'hCAFEF00D, 2, 16'h0010, 16'h0014};
        tbl[2] = '{16'h0020, 8, 32'h01020304, 32'h05060708, 2, 16'h0020, 16'h0024};
        tbl[3] = '{16'h0020, 9, 32'h11111111, 32'h22222222, 2, 16'h0020, 16'h0024};
        tbl[4] = '{16'hFFFC, 8, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 16'hFFFC, 16'h0000};
        tbl[5] = '{16'h1234, 3, 32'h99887766, 32'h0,        0, 16'h0000, 16'h0000};

        rst_i = 1'b1; rx_dat = 8'h0; rx_valid = 1'b0; stop = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_cyc", {31'h0, wb_cyc}, 0);
        check("rst_stb", {31'h0, wb_stb}, 0);
        check("rst_sel", {28'h0, wb_sel}, 0);
        check("rst_we", {31'h0, wb_we}, 0);
        check("rst_txv", {31'h0, tx_valid}, 0);
        check("rst_err", {31'h0, err}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_adr", {16'h0, wb_adr}, 0);
        check("rst_cti_bte", {27'h0, wb_cti, wb_bte}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table-driven write vectors.
        for (int i = 0; i < 6; i++) begin
            base = evq.size();
            send_hdr(1'b0, tbl[i].adr);
            for (int k = 0; k < tbl[i].nbytes; k++) begin
                if (k < 4) b = tbl[i].d0[31-8*k -: 8];
                else if (k < 8) b = tbl[i].d1[63-8*k -: 8];
                else b = 8'hAA;
                send_byte(b);
            end
            send_stop();
            wait_idle($sformatf("v%0d_idle", i));
            check($sformatf("v%0d_nwr", i), evq.size() - base, tbl[i].exp_n);
            for (int k = 0; k < tbl[i].exp_n && base + k < evq.size(); k++) begin
                check($sformatf("v%0d_adr%0d", i, k), {16'h0, evq[base+k].adr},
                      {16'h0, (k == 0) ? tbl[i].exp_a0 : tbl[i].exp_a1});
                check($sformatf("v%0d_dat%0d", i, k), evq[base+k].dat,
                      (k == 0) ? tbl[i].d0 : tbl[i].d1);
                check($sformatf("v%0d_we%0d", i, k), {31'h0, evq[base+k].we}, 1);
                ref_mem[int'((k == 0) ? tbl[i].exp_a0 : tbl[i].exp_a1)] =
                    (k == 0) ? tbl[i].d0 : tbl[i].d1;
            end
        end

        // Read with random tx_ready, then the prefetch of the next word.
        send_hdr(1'b0, 16'h0030);
        send_word(32'h11223344);
        send_stop();
        wait_idle("rd_prep_idle");
        ref_mem[32'h30] = 32'h11223344;
        ack_delay = 2;
        base = evq.size();
        send_hdr(1'b1, 16'h0030);
        collect(4);
        w = 32'h11223344;
        for (int k = 0; k < 4 && k < rxb.size(); k++)
            check($sformatf("rd_byte%0d", k), {24'h0, rxb[k]}, {24'h0, w[31-8*k -: 8]});
        t = 0;
        while (evq.size() < base + 2 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("rd_nev", evq.size() - base, 2);
        if (evq.size() >= base + 2) begin
            check("rd_we", {31'h0, evq[base].we}, 0);
            check("rd_adr0", {16'h0, evq[base].adr}, 32'h0030);
            check("rd_adr1", {16'h0, evq[base+1].adr}, 32'h0034);
        end
        send_stop();
        wait_idle("rd_stop_idle");
        check("rd_txv_drop", {31'h0, tx_valid}, 0);
        ack_delay = 0;

        // Bus error on a write: sticky flag, address held, reset clears it.
        base = evq.size();
        err_req = err_req + 1;
        send_hdr(1'b0, 16'h0040);
        send_word(32'hAAAA5555);
        send_word(32'h12345678);
        send_stop();
        wait_idle("err_idle");
        ref_mem[32'h40] = 32'h12345678;
        check("err_flag", {31'h0, err}, 1);
        check("err_nev", evq.size() - base, 2);
        if (evq.size() >= base + 2) begin
            check("err_ev0", {15'h0, evq[base].err, evq[base].adr}, {15'h0, 1'b1, 16'h0040});
            check("err_ev1", {15'h0, evq[base+1].err, evq[base+1].adr}, {15'h0, 1'b0, 16'h0040});
            check("err_dat1", evq[base+1].dat, 32'h12345678);
        end
        send_hdr(1'b0, 16'h0060);
        send_word(32'h0BADF00D);
        send_stop();
        wait_idle("err2_idle");
        ref_mem[32'h60] = 32'h0BADF00D;
        check("err_sticky", {31'h0, err}, 1);
        do_reset();
        check("err_cleared", {31'h0, err}, 0);

        // Stop while the write strobe is up and ack is slow.
        ack_delay = 5;
        base = evq.size();
        send_hdr(1'b0, 16'h0050);
        send_word(32'hCAFE0001);
        send_stop();
        check("stop_cyc_held", {31'h0, wb_cyc}, 1);
        t = 0;
        while (wb_cyc && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("stop_cyc_len", {31'h0, (t >= 3)}, 1);
        check("stop_then_idle", {31'h0, busy}, 0);
        check("stop_nev", evq.size() - base, 1);
        if (evq.size() > base) check("stop_adr", {16'h0, evq[base].adr}, 32'h0050);
        ref_mem[32'h50] = 32'hCAFE0001;

        // Reset in the middle of a bus cycle drops cyc/stb without a clock edge.
        send_hdr(1'b0, 16'h0070);
        send_word(32'h77777777);
        @(negedge clk_i);
        check("rstmid_cyc_before", {31'h0, wb_cyc}, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rstmid_cyc", {31'h0, wb_cyc}, 0);
        check("rstmid_stb", {31'h0, wb_stb}, 0);
        check("rstmid_sel", {28'h0, wb_sel}, 0);
        check("rstmid_busy", {31'h0, busy}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Randomized traffic against the reference memory.
        for (int it = 0; it < 24; it++) begin
            ack_delay = $urandom_range(0, 3);
            if (waddrs.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFC);
                n = $urandom_range(1, 3);
                base = evq.size();
                send_hdr(1'b0, a);
                for (int k = 0; k < n; k++) begin
                    d = $urandom;
                    ref_mem[int'(16'(a + 16'(4 * k)))] = d;
                    send_word(d);
                end
                send_stop();
                wait_idle($sformatf("rw%0d_idle", it));
                check($sformatf("rw%0d_nwr", it), evq.size() - base, n);
                for (int k = 0; k < n && base + k < evq.size(); k++) begin
                    check($sformatf("rw%0d_adr%0d", it, k), {16'h0, evq[base+k].adr},
                          {16'h0, 16'(a + 16'(4 * k))});
                    check($sformatf("rw%0d_dat%0d", it, k), evq[base+k].dat,
                          ref_rd(16'(a + 16'(4 * k))));
                end
                waddrs.push_back(a);
            end else begin
                a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                n = $urandom_range(1, 2);
                send_hdr(1'b1, a);
                collect(4 * n);
                for (int k = 0; k < 4 * n && k < rxb.size(); k++) begin
                    w = ref_rd(16'(a + 16'(4 * (k / 4))));
                    check($sformatf("rr%0d_b%0d", it, k), {24'h0, rxb[k]},
                          {24'h0, w[31-8*(k%4) -: 8]});
                end
                send_stop();
                wait_idle($sformatf("rr%0d_idle", it));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_wb_bridge.md
Name: i2c_wb_bridge

Overview:
- Parametrised successor to the single-byte I2C-slave-to-memory bench bridge.
- Turns an I2C-slave byte stream into Wishbone B3 classic master cycles.
- Supports both writes and reads, a configurable data width and address length, auto-increment, and error reporting.
- Sits between the bench I2C slave byte receiver/transmitter and any Wishbone memory model (e.g. ram_wb_b3).

Parameters:
- DW, 32: Wishbone data width in bits; must be 8, 16 or 32.
- AW, 16: Wishbone address width in bits.
- ADR_BYTES, 2: number of address bytes in a transaction header; range 1..4.
- AUTO_INC, 1: 1 advances the address by DW/8 after every word; 0 keeps the address fixed.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rx_dat_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe; rx_dat_i is valid in this cycle.
- stop_i  in  1  one-cycle strobe marking the I2C stop condition.
- tx_dat_o  out  8  byte to send to the I2C master.
- tx_valid_o  out  1  tx_dat_o is valid.
- tx_ready_i  in  1  transmitter accepts tx_dat_o.
- wb_adr_o  out  AW  Wishbone byte address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  byte selects; always all ones during a cycle.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  constant 3'b000 (classic cycle).
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- err_o  out  1  sticky error flag.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs go to 0 (wb_sel_o=0, tx_valid_o=0, err_o=0).
  - State goes to IDLE; address, byte counter and data registers clear.
  - An in-flight Wishbone cycle is dropped immediately.
- Header:
  - The first rx byte after IDLE is the control byte; bit0 is R/W (1=read). Other bits are ignored.
  - The next ADR_BYTES bytes shift into the address register MSB first. The register keeps the low AW bits.
- State IDLE: on rx_valid_i, latch R/W and go to ADDR.
- State ADDR:
  - Count ADR_BYTES bytes.
  - After the last byte, go to WDATA if writing, or to RD_REQ if reading.
- State WDATA:
  - Collect DW/8 bytes into a shift register. The first byte lands in the MSB lane (big-endian).
  - On the last byte, drive wb_adr_o, wb_dat_o, wb_sel_o=all ones, wb_we_o=1 and cyc=stb=1 in the next cycle, then go to WB_WR.
- State WB_WR:
  - Hold all Wishbone signals until ack or err.
  - In that cycle's following edge, drop cyc/stb/we.
  - On ack, add DW/8 to the address if AUTO_INC=1; on err, set err_o and leave the address unchanged.
  - Then return to WDATA.
- State RD_REQ:
  - Assert cyc=stb=1 with we=0.
  - On ack, latch wb_dat_i and drop cyc/stb.
  - On err, set err_o, latch 0 and drop cyc/stb.
  - Then go to TX.
- State TX:
  - Present the latched word MSB byte first with tx_valid_o=1.
  - Advance a byte only on a cycle where tx_valid_o and tx_ready_i are both high.
  - After DW/8 bytes, apply the AUTO_INC address step and go back to RD_REQ (prefetch of the next word).
- Address wrap: the address increments modulo 2^AW; FFFC+4 gives 0000.
- Stop condition:
  - stop_i in ADDR, WDATA, RD_REQ before stb is asserted, or TX goes to IDLE next cycle.
  - A partial write word is discarded with no Wishbone cycle; tx_valid_o drops.
  - stop_i during WB_WR or an outstanding read is latched. The cycle completes (ack/err), then the block goes to IDLE.
  - Read data fetched that way is discarded.
- Simultaneous events:
  - stop_i together with rx_valid_i: stop wins and the byte is ignored.
  - rx_valid_i outside IDLE/ADDR/WDATA is ignored.
- err_o clears only on reset. busy_o is low only in IDLE.
- Wishbone latency: stb rises one clock after the last data byte, or on RD_REQ entry; cycles are single-beat only.

Test Plan:
- Write, DW=32, ADR_BYTES=2: bytes 00,00,10,DE,AD,BE,EF then stop -> one WB write, adr=0010, dat=DEADBEEF, sel=F; address becomes 0014.
- Burst write of 8 data bytes from 0x0020 -> two writes, at 0020 and 0024; a 9th lone byte plus stop -> no third cycle.
- Read: memory[0x0030]=11223344, bytes 01,00,30, tx_ready_i pulsed randomly -> tx bytes 11,22,33,44; a second prefetch read occurs at 0034.
- Wrap: write at FFFC then one more word -> second write at 0000.
- wb_err_i on a write -> err_o=1 and sticky; the next word goes to the same address; a reset clears err_o.
- stop_i while stb is high with ack delayed 5 cycles -> cyc held until ack, then IDLE; rst_i mid-cycle -> cyc/stb drop asynchronously.
